// File: rtl/pipeline_stage_skid_n.sv
// pipeline_stage_skid_n: address-offset pipeline stage with a DEPTH-entry in-order skid FIFO, flush and occupancy.
module pipeline_stage_skid_n #(
  parameter int ADDR_W = 32,
  parameter int ID_W = 8,
  parameter int DEPTH = 2,
  parameter int WRAP_EN = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            stage_offset,
  input  logic [ADDR_W-1:0]            addr_limit,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            in_address,
  input  logic [ID_W-1:0]              in_id,
  input  logic                         in_valid,
  output logic                         out_stall,
  output logic [ADDR_W-1:0]            out_address,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_valid,
  input  logic                         in_stall,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ID_W-1:0]   id_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;
  logic [ADDR_W:0]   sum, lim;
  logic [ADDR_W-1:0] res;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction
  assign out_stall   = count_q == CW'(DEPTH);
  assign out_valid   = count_q != '0;
  assign occupancy   = count_q;
  assign out_address = addr_q[rd_q];
  assign out_id      = id_q[rd_q];
  assign push        = in_valid & ~out_stall & ~flush;
  assign pop         = out_valid & ~in_stall & ~flush;
  // A zero limit stands for 2^ADDR_W; only one subtraction is ever applied.
  always_comb begin
    sum     = {1'b0, in_address} + {1'b0, stage_offset};
    lim     = (addr_limit == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, addr_limit};
    res     = (WRAP_EN != 0 && sum >= lim) ? ADDR_W'(sum - lim) : sum[ADDR_W-1:0];
    wr_d    = flush ? '0 : push ? inc(wr_q) : wr_q;
    rd_d    = flush ? '0 : pop ? inc(rd_q) : rd_q;
    count_d = flush ? '0 : (push && !pop) ? count_q + CW'(1) :
              (pop && !push) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push) begin
        addr_q[wr_q] <= res;
        id_q[wr_q]   <= in_id;
      end
    end
  end
endmodule

// File: doc/pipeline_stage_skid_n.md
Name: pipeline_stage_skid_n

Overview:
- Parametrised successor to the two-register address pipeline stage.
- Each accepted beat gets `in_address + stage_offset` applied, with optional modulo-limit wrap, and carries its `in_id` unchanged.
- Beats are held in a DEPTH-entry in-order skid FIFO with a registered-only backpressure path.
- Adds a synchronous flush and an occupancy output; instances are chained to form the address pipeline.

Parameters:
- ADDR_W, 32, address width in bits.
- ID_W, 8, transaction ID width.
- DEPTH, 2, skid FIFO entries; legal range 2..16.
- WRAP_EN, 0, selects the address arithmetic mode:
  - 0: result is (in_address + stage_offset) mod 2^ADDR_W.
  - 1: result wraps modulo addr_limit.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stage_offset  input  ADDR_W  per-stage address offset; quasi-static.
- addr_limit  input  ADDR_W  wrap modulus when WRAP_EN=1; 0 means 2^ADDR_W; quasi-static.
- flush  input  1  synchronous discard of all held beats.
- in_address  input  ADDR_W  upstream address.
- in_id  input  ID_W  upstream ID.
- in_valid  input  1  upstream beat valid.
- out_stall  output  1  backpressure to upstream; 1 means this cycle's beat is not accepted.
- out_address  output  ADDR_W  head-entry address.
- out_id  output  ID_W  head-entry ID.
- out_valid  output  1  head entry valid.
- in_stall  input  1  downstream backpressure.
- occupancy  output  $clog2(DEPTH+1)  number of held entries.

Behaviour:
- Reset, synchronous and taking priority over everything:
  - count, rd_ptr and wr_ptr go to 0.
  - out_valid=0, out_stall=0, occupancy=0.
  - out_address=0 and out_id=0; storage entries are also zeroed.
- Handshake and ordering:
  - push = in_valid & ~out_stall & ~flush.
  - pop = out_valid & ~in_stall & ~flush.
  - Beats leave in strict arrival order.
  - A beat presented while out_stall=1 is not consumed; upstream must hold it.
- Backpressure:
  - out_stall = (count == DEPTH). It is a function of registers only; there is no combinational path from in_stall to out_stall.
  - When full, a simultaneous pop does not enable a push in the same cycle. Accepted cost: one bubble at full.
- Outputs:
  - out_valid = (count != 0).
  - out_address and out_id always show entry[rd_ptr].
  - Outputs hold stable while out_valid & in_stall.
- Latency and throughput:
  - A beat pushed at edge N is visible on the outputs after edge N when the FIFO was empty, i.e. one-cycle latency.
  - Sustained throughput is 1 beat/cycle whenever in_stall=0.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
  - Pointers wrap modulo DEPTH; DEPTH is not required to be a power of 2.
- Address arithmetic, computed at push time into the stored entry:
  - sum = {1'b0,in_address} + {1'b0,stage_offset}, ADDR_W+1 bits.
  - WRAP_EN=0: store sum[ADDR_W-1:0].
  - WRAP_EN=1, limit L (2^ADDR_W when addr_limit=0): store sum-L if sum >= L, else sum, truncated to ADDR_W.
  - Only one subtraction is performed. Inputs with in_address >= L or stage_offset >= L produce the single-subtract result and are not flagged.
- ID: stored unmodified.
- Flush:
  - When flush=1 at an edge: count and pointers go to 0, and out_valid=0 after the edge.
  - The in_valid beat presented in the flush cycle is dropped.
  - No pop is counted in the flush cycle, even if in_stall=0.
  - out_stall falls to 0 after the flush edge.
- Reset mid-operation: identical to flush, and storage is also cleared.
- Occupancy: equals count at all times; reaches DEPTH exactly when out_stall=1.

Test Plan:
- Stream, no stall, WRAP_EN=0, stage_offset=0x10:
  - Stimulus: in_address 0x0..0x7, ids 0..7 on consecutive cycles, in_stall=0.
  - Response: outputs 0x10..0x17 with ids 0..7, each one cycle after acceptance, out_stall never asserted.
- Fill and drain, DEPTH=4:
  - Stimulus: in_stall=1 while 6 beats are offered.
  - Response: first 4 accepted, out_stall=1 and occupancy=4, out_valid stays 1 with out_address stable.
  - Then release in_stall: beats drain in order and the held 5th and 6th beats are accepted once count<4; no loss or duplication.
- Wrap modulus, WRAP_EN=1, addr_limit=100, stage_offset=30:
  - Stimulus: in_address 60, 69, 70, 99.
  - Response: out_address 90, 99, 0, 29.
- Default wrap, WRAP_EN=0, ADDR_W=8:
  - Stimulus: in_address 0xF0, stage_offset 0x20.
  - Response: out_address 0x10.
- Flush with simultaneous push, DEPTH=4:
  - Stimulus: 3 entries held, flush=1 together with in_valid=1, in_stall=0.
  - Response: next cycle out_valid=0, occupancy=0, out_stall=0, and the flushed-cycle beat never appears.
- Reset mid-stream:
  - Stimulus: reset asserted while full and stalled.
  - Response: after the edge all outputs are 0; the first beat after reset deasserts emerges with one-cycle latency.
